// File: rtl/dmux_lane_collector_if.sv
// Bus bundle between the bit demux, the lane collector and the word consumer.
// The collector uses the slave modport; the demux/consumer side uses master.
interface dmux_lane_collector_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       din;
    logic [1:0]       sel;
    logic             stb;
    logic [WIDTH-1:0] word;
    logic [1:0]       lane;
    logic             valid;
    logic             ready;
    logic             overflow;
    logic             err;

    modport master (
        output din, sel, stb, ready,
        input  word, lane, valid, overflow, err
    );

    modport slave (
        input  din, sel, stb, ready,
        output word, lane, valid, overflow, err
    );
endinterface

// File: rtl/dmux_lane_collector.sv
// Collects serial demux lane bits into WIDTH-bit words (LSB first), one hold slot per lane,
// round-robin onto a valid/ready output. Optional one-hot lane check: DMUX_ONEHOT_CHECK_EN.
module dmux_lane_collector #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    dmux_lane_collector_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr        [4];
    logic [CW-1:0]    cnt       [4];
    logic [WIDTH-1:0] hold      [4];
    logic [3:0]       hold_full;
    logic [1:0]       ptr;

    logic [WIDTH-1:0] word_q;
    logic [1:0]       lane_q;
    logic             valid_q;
    logic             overflow_q;

    logic             bit_in;
    logic [WIDTH-1:0] next_word;
    logic             done;
    logic [1:0]       win;
    logic             load;
    logic             slot_free;

    assign bit_in    = bus.din[bus.sel];
    assign next_word = {bit_in, sr[bus.sel][WIDTH-1:1]};
    assign done      = bus.stb && (cnt[bus.sel] == CNT_LAST);
    assign load      = (!valid_q || bus.ready) && (|hold_full);
    // A full hold slot still accepts a new word if it empties into the output this same cycle.
    assign slot_free = !hold_full[bus.sel] || (load && (win == bus.sel));

    // First full lane scanning upward from the round-robin pointer.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && hold_full[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-lane arrays are cleared on reset so no partial word survives it.
            for (int n = 0; n < 4; n++) begin
                sr[n]   <= '0;
                cnt[n]  <= '0;
                hold[n] <= '0;
            end
            hold_full  <= '0;
            ptr        <= '0;
            word_q     <= '0;
            lane_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (load) begin
                word_q         <= hold[win];
                lane_q         <= win;
                valid_q        <= 1'b1;
                hold_full[win] <= 1'b0;
                ptr            <= win + 2'd1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end

            if (bus.stb) begin
                sr[bus.sel] <= next_word;
                if (done) begin
                    cnt[bus.sel] <= '0;
                    if (slot_free) begin
                        hold[bus.sel] <= next_word;
                        // NOTE: this later non-blocking write overrides the clear from the load above.
                        hold_full[bus.sel] <= 1'b1;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end else begin
                    cnt[bus.sel] <= cnt[bus.sel] + CW'(1);
                end
            end
        end
    end

`ifdef DMUX_ONEHOT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.stb && ((bus.din & ~(4'b0001 << bus.sel)) != 4'b0000)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.word     = word_q;
    assign bus.lane     = lane_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;
endmodule
